// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: recovers pixel coordinates and data-enable
// from a sync/blank/RGB stream, measures geometry, locks and flags violations.
module vga_sync_decoder #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_TOTAL     = 525,
  parameter bit          HS_POL      = 1'b0,
  parameter bit          VS_POL      = 1'b0,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iHS,
  input  logic        iVS,
  input  logic        iBLANK,
  input  logic [3:0]  iRed,
  input  logic [3:0]  iGreen,
  input  logic [3:0]  iBlue,
  input  logic        iCLR_ERR,
  output logic [9:0]  oX,
  output logic [9:0]  oY,
  output logic        oDE,
  output logic [3:0]  oR,
  output logic [3:0]  oG,
  output logic [3:0]  oB,
  output logic        oLOCKED,
  output logic        oFRAME_START,
  output logic [10:0] oLINE_LEN,
  output logic [15:0] oFRAME_CNT,
  output logic [2:0]  oERR
);

  localparam logic [11:0] H_TOTAL_L  = 12'(H_TOTAL);
  localparam logic [9:0]  H_ACTIVE_L = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACTIVE_L = 10'(V_ACTIVE);
  localparam logic [9:0]  V_TOTAL_L  = 10'(V_TOTAL);
  localparam logic [2:0]  LOCK_L     = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  state_t      state_q, state_d;
  logic [2:0]  good_q, good_d;
  logic [2:0]  err_set;

  // Sync levels are stored polarity-corrected (1 = asserted)
  logic        hs1, hs2, vs1, vs2, act1, act2;
  logic [3:0]  r1, g1, b1;
  logic [10:0] hcnt;
  logic [11:0] hcnt_inc;
  logic [9:0]  lcnt, lcnt_now, acnt, pcnt;
  logic        line_flag, width_flag;
  logic        hs_edge, vs_edge, run_end;
  logic        line_err_now, width_err_now, frame_err_now, frame_ok;

  assign hs_edge  = hs1 & ~hs2;
  assign vs_edge  = vs1 & ~vs2;
  assign run_end  = act2 & ~act1;
  assign hcnt_inc = {1'b0, hcnt} + 12'd1;

  // Line count including a coincident HS edge, so the VS check sees that line
  always_comb begin
    lcnt_now = lcnt;
    if (hs_edge && lcnt != '1) lcnt_now = lcnt + 10'd1;
  end

  assign line_err_now  = hs_edge & (hcnt_inc != H_TOTAL_L);
  assign width_err_now = run_end & (pcnt != H_ACTIVE_L);
  assign frame_err_now = vs_edge & ((lcnt_now != V_TOTAL_L) | (acnt != V_ACTIVE_L));
  assign frame_ok      = ~(line_flag | line_err_now | width_flag | width_err_now |
                           (lcnt_now != V_TOTAL_L) | (acnt != V_ACTIVE_L));

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= SEARCH;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_set = '0;
    case (state_q)
      SEARCH: begin
        if (vs_edge) begin
          state_d = ALIGN;
          good_d  = '0;
        end
      end
      ALIGN: begin
        if (vs_edge) begin
          if (!frame_ok) begin
            good_d = '0;
          end else if (good_q + 3'd1 == LOCK_L) begin
            state_d = LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_q + 3'd1;
          end
        end
      end
      LOCKED: begin
        err_set = {width_err_now, frame_err_now, line_err_now};
        if (err_set != '0) state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase
  end

  assign oLOCKED = (state_q == LOCKED);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      hs1 <= 1'b0; hs2 <= 1'b0; vs1 <= 1'b0; vs2 <= 1'b0;
      act1 <= 1'b0; act2 <= 1'b0;
      r1 <= '0; g1 <= '0; b1 <= '0;
      hcnt <= '0; lcnt <= '0; acnt <= '0; pcnt <= '0;
      line_flag <= 1'b0; width_flag <= 1'b0;
      oX <= '0; oY <= '0; oDE <= 1'b0;
      oR <= '0; oG <= '0; oB <= '0;
      oFRAME_START <= 1'b0; oLINE_LEN <= '0; oFRAME_CNT <= '0; oERR <= '0;
    end else begin
      hs1  <= (iHS == HS_POL);
      hs2  <= hs1;
      vs1  <= (iVS == VS_POL);
      vs2  <= vs1;
      act1 <= iBLANK;
      act2 <= act1;
      r1   <= iRed;
      g1   <= iGreen;
      b1   <= iBlue;

      if (hs_edge) begin
        hcnt      <= '0;
        oLINE_LEN <= hcnt_inc[11] ? '1 : hcnt_inc[10:0];
      end else if (hcnt != '1) begin
        hcnt <= hcnt + 11'd1;
      end

      if (vs_edge) begin
        lcnt <= '0;
        acnt <= '0;
      end else begin
        lcnt <= lcnt_now;
        if (run_end && acnt != '1) acnt <= acnt + 10'd1;
      end

      if (!act1)          pcnt <= '0;
      else if (pcnt != '1) pcnt <= pcnt + 10'd1;

      if (vs_edge) begin
        line_flag  <= 1'b0;
        width_flag <= 1'b0;
      end else begin
        line_flag  <= line_flag | line_err_now;
        width_flag <= width_flag | width_err_now;
      end

      oERR <= (iCLR_ERR ? 3'b000 : oERR) | err_set;

      oR  <= r1;
      oG  <= g1;
      oB  <= b1;
      oX  <= act1 ? pcnt : '0;
      oY  <= act1 ? acnt : '0;
      oDE <= act1 && (state_d == LOCKED);
      oFRAME_START <= vs_edge && (state_q == LOCKED);
      if (vs_edge && state_q == LOCKED) oFRAME_CNT <= oFRAME_CNT + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled 8x4 (16x8 total) raster
// with active-low syncs; VS asserts on the HS edge of line 5.
module tb_vga_sync_decoder;

  logic        iCLK = 1'b0;
  logic        iRST, iHS, iVS, iBLANK, iCLR_ERR;
  logic [3:0]  iRed, iGreen, iBlue;
  logic [9:0]  oX, oY;
  logic        oDE, oLOCKED, oFRAME_START;
  logic [3:0]  oR, oG, oB;
  logic [10:0] oLINE_LEN;
  logic [15:0] oFRAME_CNT;
  logic [2:0]  oERR;
  logic [64:0] out_all;

  always #5 iCLK = ~iCLK;

  vga_sync_decoder #(
    .H_ACTIVE(8), .H_TOTAL(16), .V_ACTIVE(4), .V_TOTAL(8),
    .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_FRAMES(2)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iHS(iHS), .iVS(iVS), .iBLANK(iBLANK),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue), .iCLR_ERR(iCLR_ERR),
    .oX(oX), .oY(oY), .oDE(oDE), .oR(oR), .oG(oG), .oB(oB),
    .oLOCKED(oLOCKED), .oFRAME_START(oFRAME_START), .oLINE_LEN(oLINE_LEN),
    .oFRAME_CNT(oFRAME_CNT), .oERR(oERR)
  );

  assign out_all = {oX, oY, oDE, oR, oG, oB, oLOCKED, oFRAME_START, oLINE_LEN, oFRAME_CNT, oERR};

  int checks = 0, errors = 0, cyc = 0, de_cnt = 0;
  int lock_fall_cyc, lock_rise_cyc, clr_cyc, err_zero_cyc, vs_in_cyc;
  int err_rise_cyc [3];
  int hs_cyc_of [8];
  bit sweep_on = 0, clr_req = 0, vs_lvl = 0, vs_in_prev = 0, lk_prev = 0;
  logic [2:0] err_prev = '0;
  bit d1_act = 0, d2_act = 0, d1_fs = 0, d2_fs = 0;
  int d1_x = 0, d2_x = 0, d1_y = 0, d2_y = 0;
  logic [11:0] d1_rgb = '0, d2_rgb = '0;

  // One pixel clock: sample outputs of the input driven two ticks ago, then drive
  task automatic tick(input int h, input int v, input bit act, input bit hs, input bit vs);
    bit fs;
    @(posedge iCLK); #1;
    cyc++;
    if (lk_prev && !oLOCKED) lock_fall_cyc = cyc;
    if (!lk_prev && oLOCKED) lock_rise_cyc = cyc;
    if (err_prev != 3'b000 && oERR == 3'b000) err_zero_cyc = cyc;
    for (int k = 0; k < 3; k++) if (!err_prev[k] && oERR[k]) err_rise_cyc[k] = cyc;
    lk_prev  = oLOCKED;
    err_prev = oERR;
    if (oDE) de_cnt++;
    if (sweep_on) begin
      checks++;
      if (oDE !== d2_act) begin
        errors++; $display("FAIL sweep_de cyc=%0d: got %0b expected %0b", cyc, oDE, d2_act);
      end
      if (d2_act) begin
        checks++;
        if (oX !== 10'(d2_x) || oY !== 10'(d2_y)) begin
          errors++; $display("FAIL sweep_xy cyc=%0d: got (%0d,%0d) expected (%0d,%0d)", cyc, oX, oY, d2_x, d2_y);
        end
      end
      checks++;
      if ({oR, oG, oB} !== d2_rgb) begin
        errors++; $display("FAIL sweep_rgb cyc=%0d: got %h expected %h", cyc, {oR, oG, oB}, d2_rgb);
      end
      checks++;
      if (oFRAME_START !== d2_fs) begin
        errors++; $display("FAIL sweep_frame_start cyc=%0d: got %0b expected %0b", cyc, oFRAME_START, d2_fs);
      end
    end
    fs = vs && !vs_in_prev;
    if (fs) vs_in_cyc = cyc;
    vs_in_prev = vs;
    d2_act = d1_act; d2_x = d1_x; d2_y = d1_y; d2_rgb = d1_rgb; d2_fs = d1_fs;
    d1_act = act; d1_x = h; d1_y = v; d1_rgb = {4'(h), 4'(v), 4'(h + v)}; d1_fs = fs;
    iCLR_ERR = clr_req;
    if (clr_req) clr_cyc = cyc;
    clr_req = 0;
    iHS = ~hs; iVS = ~vs; iBLANK = act;
    iRed = 4'(h); iGreen = 4'(v); iBlue = 4'(h + v);
  endtask

  task automatic send_frame(input int nlines, input int bad_line, input int bad_len, input int bad_act);
    int len, a;
    for (int v = 0; v < nlines; v++) begin
      len = 16;
      a   = (v < 4) ? 8 : 0;
      if (v == bad_line) begin
        len = bad_len;
        a   = bad_act;
      end
      for (int h = 0; h < len; h++) begin
        if (h == 10) vs_lvl = (v == 5 || v == 6);
        tick(h, v, h < a, (h >= 10 && h < 12), vs_lvl);
        if (h == 10) hs_cyc_of[v] = cyc;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge iCLK);
    #1;
    checks++;
    if (out_all !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", out_all);
    end
    iRST = 0;
  endtask

  task automatic test_nominal;
    send_frame(8, -1, 16, 8);
    send_frame(8, -1, 16, 8);
    checks++;
    if (oLOCKED !== 1'b0) begin
      errors++; $display("FAIL nominal_no_early_lock: got %0b expected 0", oLOCKED);
    end
    send_frame(8, -1, 16, 8);
    checks++;
    if (oLOCKED !== 1'b1 || lock_rise_cyc != vs_in_cyc + 2) begin
      errors++; $display("FAIL nominal_lock_time: locked %0b at cyc %0d expected 1 at cyc %0d", oLOCKED, lock_rise_cyc, vs_in_cyc + 2);
    end
    de_cnt   = 0;
    sweep_on = 1;
    send_frame(8, -1, 16, 8);
    sweep_on = 0;
    checks++;
    if (de_cnt != 32) begin
      errors++; $display("FAIL nominal_de_count: got %0d expected 32", de_cnt);
    end
    checks++;
    if (oLINE_LEN !== 11'd16 || oERR !== 3'b000) begin
      errors++; $display("FAIL nominal_geometry: got len %0d err %b expected len 16 err 000", oLINE_LEN, oERR);
    end
    checks++;
    if (oFRAME_CNT !== 16'd1) begin
      errors++; $display("FAIL nominal_frame_cnt1: got %0d expected 1", oFRAME_CNT);
    end
    send_frame(8, -1, 16, 8);
    checks++;
    if (oFRAME_CNT !== 16'd2) begin
      errors++; $display("FAIL nominal_frame_cnt2: got %0d expected 2", oFRAME_CNT);
    end
  endtask

  task automatic test_line_err;
    for (int k = 0; k < 3; k++) err_rise_cyc[k] = -1;
    lock_fall_cyc = -1;
    send_frame(8, 2, 15, 8);
    checks++;
    if (err_rise_cyc[0] != hs_cyc_of[3] + 2 || lock_fall_cyc != hs_cyc_of[3] + 2) begin
      errors++; $display("FAIL line_err_timing: err at %0d unlock at %0d expected %0d", err_rise_cyc[0], lock_fall_cyc, hs_cyc_of[3] + 2);
    end
    checks++;
    if (oERR !== 3'b001 || oLOCKED !== 1'b0) begin
      errors++; $display("FAIL line_err_flag: got err %b locked %0b expected 001 0", oERR, oLOCKED);
    end
    send_frame(8, -1, 16, 8);
    checks++;
    if (oLOCKED !== 1'b0) begin
      errors++; $display("FAIL line_err_relock_early: got %0b expected 0", oLOCKED);
    end
    send_frame(8, -1, 16, 8);
    checks++;
    if (oLOCKED !== 1'b1 || oERR !== 3'b001) begin
      errors++; $display("FAIL line_err_relock: got locked %0b err %b expected 1 001", oLOCKED, oERR);
    end
  endtask

  task automatic test_frame_lines;
    err_zero_cyc = -1;
    clr_req = 1;
    send_frame(7, -1, 16, 8);
    checks++;
    if (err_zero_cyc != clr_cyc + 1 || oERR !== 3'b000) begin
      errors++; $display("FAIL clear_err: cleared at %0d err %b expected %0d 000", err_zero_cyc, oERR, clr_cyc + 1);
    end
    err_rise_cyc[1] = -1;
    send_frame(8, -1, 16, 8);
    checks++;
    if (err_rise_cyc[1] != vs_in_cyc + 2 || oERR !== 3'b010 || oLOCKED !== 1'b0) begin
      errors++; $display("FAIL frame_lines_err: err %b at %0d locked %0b expected 010 at %0d 0", oERR, err_rise_cyc[1], oLOCKED, vs_in_cyc + 2);
    end
    repeat (3) send_frame(8, -1, 16, 8);
    checks++;
    if (oLOCKED !== 1'b1) begin
      errors++; $display("FAIL frame_lines_relock: got %0b expected 1", oLOCKED);
    end
  endtask

  task automatic test_width;
    clr_req = 1;
    de_cnt  = 0;
    send_frame(8, 1, 16, 9);
    checks++;
    if (oERR !== 3'b100 || oLOCKED !== 1'b0) begin
      errors++; $display("FAIL width_err: got err %b locked %0b expected 100 0", oERR, oLOCKED);
    end
    checks++;
    if (de_cnt != 17) begin
      errors++; $display("FAIL width_de_drop: got %0d DE cycles expected 17", de_cnt);
    end
    repeat (3) send_frame(8, -1, 16, 8);
    checks++;
    if (oLOCKED !== 1'b1) begin
      errors++; $display("FAIL width_relock: got %0b expected 1", oLOCKED);
    end
  endtask

  task automatic test_reset_mid;
    bit found = 0;
    for (int h = 0; h < 16 && !found; h++) begin
      tick(h, 0, h < 8, (h >= 10 && h < 12), vs_lvl);
      if (oDE === 1'b1 && oX === 10'd3) found = 1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL reset_mid_x3: got found=%0b expected 1", found);
    end
    iRST = 1;
    #1;
    checks++;
    if (out_all !== '0) begin
      errors++; $display("FAIL reset_mid_outputs: got %h expected 0", out_all);
    end
    iHS = 1; iVS = 1; iBLANK = 0;
    repeat (3) @(posedge iCLK);
    #1;
    checks++;
    if (out_all !== '0 || dut.hcnt !== 11'd0) begin
      errors++; $display("FAIL reset_mid_hold: got %h hcnt %0d expected 0 0", out_all, dut.hcnt);
    end
    iRST = 0;
    vs_lvl = 0; vs_in_prev = 0; lk_prev = 0; err_prev = '0;
    send_frame(8, -1, 16, 8);
    send_frame(8, -1, 16, 8);
    checks++;
    if (oLOCKED !== 1'b0) begin
      errors++; $display("FAIL reset_mid_no_early_lock: got %0b expected 0", oLOCKED);
    end
    send_frame(8, -1, 16, 8);
    checks++;
    if (oLOCKED !== 1'b1 || oFRAME_CNT !== 16'd0) begin
      errors++; $display("FAIL reset_mid_relock: got locked %0b cnt %0d expected 1 0", oLOCKED, oFRAME_CNT);
    end
  endtask

  task automatic test_idle;
    send_frame(8, 2, 15, 8);
    de_cnt = 0;
    for (int i = 0; i < 3000; i++) tick(0, 0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (oLOCKED !== 1'b0 || de_cnt != 0) begin
      errors++; $display("FAIL idle_unlocked: got locked %0b de %0d expected 0 0", oLOCKED, de_cnt);
    end
    checks++;
    if (dut.hcnt !== 11'd2047) begin
      errors++; $display("FAIL idle_hcnt_sat: got %0d expected 2047", dut.hcnt);
    end
    checks++;
    if (oLINE_LEN !== 11'd16) begin
      errors++; $display("FAIL idle_line_len_hold: got %0d expected 16", oLINE_LEN);
    end
  endtask

  initial begin
    iRST = 1; iHS = 1; iVS = 1; iBLANK = 0; iCLR_ERR = 0;
    iRed = '0; iGreen = '0; iBlue = '0;
    test_reset;
    test_nominal;
    test_line_err;
    test_frame_lines;
    test_width;
    test_reset_mid;
    test_idle;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
